seq_shifter: RTL and testbench

- Parametrised, multi-mode sequential shifter; successor to the team's fixed 4-bit single-position left shifter.
- Shifts a WIDTH-bit operand by a run-time amount, one bit position per clock, through a single internal register.
- Supports logical left, logical right, arithmetic right and rotate left, with a start/busy/done handshake.
- Sits in the datapath next to the ALU, where a multi-cycle shift is acceptable in exchange for small area.

---
 rtl/seq_shifter.sv | 106 ++++++++++
 tb/tb_seq_shifter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-mode sequential shifter that moves one bit position per clock.
// Ports: clk, rst, start/in/amt/mode/cin request; out/cout/busy/done result.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t next;

  logic [AMT_W-1:0] count;
  logic [1:0]       mode_q;
  logic             cin_q;
  logic             accept;
  logic [WIDTH-1:0] step_out;
  logic             step_cout;

  // Requests are taken in IDLE, DONE and any illegal encoding.
  assign accept = start && (state != SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = IDLE;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SHIFT: begin
        busy = 1'b1;
        next = (count == AMT_W'(1)) ? DONE : SHIFT;
      end
      DONE: begin
        done = 1'b1;
        if (accept) next = (amt != '0) ? SHIFT : DONE;
      end
      default: begin
        if (accept) next = (amt != '0) ? SHIFT : DONE;
      end
    endcase
  end

  always_comb begin
    step_out  = out;
    step_cout = cout;
    unique case (mode_q)
      2'b00: begin
        step_out  = {out[WIDTH-2:0], cin_q};
        step_cout = out[WIDTH-1];
      end
      2'b01: begin
        step_out  = {cin_q, out[WIDTH-1:1]};
        step_cout = out[0];
      end
      2'b10: begin
        step_out  = {out[WIDTH-1], out[WIDTH-1:1]};
        step_cout = out[0];
      end
      default: begin
        step_out  = {out[WIDTH-2:0], out[WIDTH-1]};
        step_cout = out[WIDTH-1];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      cout   <= 1'b0;
      count  <= '0;
      mode_q <= 2'b00;
      cin_q  <= 1'b0;
    end else if (accept) begin
      out    <= in;
      cout   <= 1'b0;
      count  <= amt;
      mode_q <= mode;
      cin_q  <= cin;
    end else if (state == SHIFT) begin
      out   <= step_out;
      cout  <= step_cout;
      count <= count - AMT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=8).
// Directed plan steps plus randomized operations against a reference model.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in = '0;
  logic [2:0] amt = '0;
  logic [1:0] mode = '0;
  logic       cin = 1'b0;
  logic [7:0] out;
  logic       cout;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  seq_shifter #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .amt(amt),
    .mode(mode), .cin(cin), .out(out), .cout(cout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result computed arithmetically: {cout, out}.
  function automatic logic [8:0] model(input logic [7:0] a, input int n,
                                       input logic [1:0] m, input logic c);
    int unsigned w;
    int unsigned mask;
    int unsigned r;
    logic signed [7:0] sa;
    logic co;
    if (n == 0) return {1'b0, a};
    w = {24'b0, a};
    mask = (32'd1 << n) - 1;
    sa = a;
    case (m)
      2'b00: begin
        r = (w << n) | (c ? mask : 0);
        co = a[8-n];
      end
      2'b01: begin
        r = (w >> n) | (c ? (mask << (8 - n)) : 0);
        co = a[n-1];
      end
      2'b10: begin
        r = {24'b0, 8'(sa >>> n)};
        co = a[n-1];
      end
      default: begin
        r = (w << n) | (w >> (8 - n));
        co = a[8-n];
      end
    endcase
    return {co, 8'(r & 32'hFF)};
  endfunction

  // Called at a negedge while the DUT can accept; returns at the negedge
  // of the done cycle. poke injects a start with new operands mid-shift.
  task automatic op(input string tag, input logic [7:0] a, input int n,
                    input logic [1:0] m, input logic c, input bit poke);
    logic [8:0] exp;
    exp = model(a, n, m, c);
    start = 1'b1; in = a; amt = 3'(n); mode = m; cin = c;
    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 1) begin
        start = 1'b1;
        in = 8'($urandom);
        amt = 3'($urandom);
        mode = 2'($urandom);
        cin = 1'($urandom);
      end
      if (k < n) chk({tag, " busy"}, {busy, done}, 2'b10);
    end
    start = 1'b0;
    chk({tag, " done"}, {busy, done}, 2'b01);
    chk({tag, " out"}, out, exp[7:0]);
    chk({tag, " cout"}, cout, exp[8]);
  endtask

  initial begin
    #2;
    chk("rst out", out, 8'h00);
    chk("rst flags", {cout, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op("t1", 8'b1001_0110, 1, 2'b00, 1'b1, 1'b0);
    chk("t1 ref", out, 8'b0010_1101);
    @(negedge clk);
    chk("t1 idle", {busy, done}, 2'b00);

    op("t2a", 8'b1000_0000, 3, 2'b10, 1'b0, 1'b0);
    chk("t2a ref", {cout, out}, 9'b0_1111_0000);
    @(negedge clk);
    op("t2b", 8'b0000_0101, 2, 2'b01, 1'b0, 1'b0);
    chk("t2b ref", {cout, out}, 9'b0_0000_0001);
    @(negedge clk);

    op("t3", 8'b1000_0001, 7, 2'b11, 1'b0, 1'b1);
    chk("t3 ref", {cout, out}, 9'b0_1100_0000);
    @(negedge clk);

    op("t4", 8'hA5, 0, 2'b01, 1'b1, 1'b0);
    chk("t4 ref", {cout, out}, 9'h0A5);

    // Back-to-back: start raised during the previous done cycle.
    op("t5", 8'h01, 4, 2'b00, 1'b0, 1'b0);
    chk("t5 ref", {cout, out}, 9'h010);
    @(negedge clk);
    chk("t5 drop", done, 1'b0);

    start = 1'b1; in = 8'hFF; amt = 3'd5; mode = 2'b01; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6 async out", out, 8'h00);
    chk("t6 async flags", {cout, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6 no stale", {busy, done}, 2'b00);
    end
    op("t6 new", 8'h3C, 2, 2'b10, 1'b0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op("rand", 8'($urandom), int'($urandom_range(0, 7)),
         2'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
